// File: rtl/afu_job_sequencer_if.sv
// Engine-side bus bundle for the AFU job sequencer: prefetch reader requests and
// responses, engine result lines, writer requests/acks and the completion record.
interface afu_job_sequencer_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 20
) ();
    logic              rd_req_valid;
    logic [ADDR_W-1:0] rd_req_addr;
    logic              rd_req_ready;
    logic              rd_rsp_valid;
    logic              res_valid;
    logic              res_ready;
    logic              wr_req_valid;
    logic [ADDR_W-1:0] wr_req_addr;
    logic              wr_req_ready;
    logic              wr_ack;
    logic              stat_wr_valid;
    logic [LEN_W+1:0]  stat_wr_data;
    logic              stat_wr_ready;

    // Sequencer side
    modport master (
        output rd_req_valid, rd_req_addr,
        input  rd_req_ready, rd_rsp_valid,
        input  res_valid,
        output res_ready,
        output wr_req_valid, wr_req_addr,
        input  wr_req_ready, wr_ack,
        output stat_wr_valid, stat_wr_data,
        input  stat_wr_ready
    );

    // Reader / engine / writer / status side
    modport slave (
        input  rd_req_valid, rd_req_addr,
        output rd_req_ready, rd_rsp_valid,
        output res_valid,
        input  res_ready,
        input  wr_req_valid, wr_req_addr,
        output wr_req_ready, wr_ack,
        input  stat_wr_valid, stat_wr_data,
        output stat_wr_ready
    );
endinterface

// File: rtl/afu_job_sequencer.sv
// AFU job sequencer: latches a job on csr_start, issues credit-limited line reads,
// forwards engine results to consecutive destination lines, counts write acks and
// posts one completion record before holding done.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | no job since reset; waiting for csr_start
//  ST_RUN    | issuing reads and forwarding results as writes
//  ST_DRAIN  | aborted; waiting for outstanding reads and write acks
//  ST_STATUS | completion record presented until stat_wr_ready
//  ST_DONE   | record posted, done held; a new csr_start is accepted
module afu_job_sequencer #(
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 20,
    parameter int MAX_OUTS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              csr_start,
    input  logic              csr_abort,
    input  logic [ADDR_W-1:0] csr_src_addr,
    input  logic [ADDR_W-1:0] csr_dst_addr,
    input  logic [LEN_W-1:0]  csr_num_lines,
    afu_job_sequencer_if.master bus,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_STATUS = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] MAX_OUTS_L = LEN_W'(MAX_OUTS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  n_q, n_d;
    logic [LEN_W-1:0]  rd_issued_q, rd_issued_d;
    logic [LEN_W-1:0]  wr_issued_q, wr_issued_d;
    logic [LEN_W-1:0]  wr_acked_q, wr_acked_d;
    logic [LEN_W-1:0]  outs_q, outs_d;
    logic              aborted_q, aborted_d;
    logic              done_q, done_d;

    logic rd_valid;
    logic wr_valid;
    logic rd_hs;
    logic wr_hs;
    logic rsp_take;
    logic in_flight;

    // Request valids come only from registered state and counters; res_valid gates the
    // write valid because a write needs a result line to carry.
    always_comb begin
        rd_valid  = (state_q == ST_RUN) && (rd_issued_q < n_q) && (outs_q < MAX_OUTS_L);
        wr_valid  = (state_q == ST_RUN) && bus.res_valid && (wr_issued_q < n_q);
        rd_hs     = rd_valid && bus.rd_req_ready;
        wr_hs     = wr_valid && bus.wr_req_ready;
        in_flight = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        // A response with nothing outstanding is stale (e.g. from before a reset).
        rsp_take  = in_flight && bus.rd_rsp_valid && (outs_q != '0);
    end

    assign bus.rd_req_valid  = rd_valid;
    assign bus.rd_req_addr   = src_q + ADDR_W'(rd_issued_q);
    assign bus.wr_req_valid  = wr_valid;
    assign bus.wr_req_addr   = dst_q + ADDR_W'(wr_issued_q);
    assign bus.res_ready     = wr_hs;
    assign bus.stat_wr_valid = (state_q == ST_STATUS);
    assign bus.stat_wr_data  = (state_q == ST_STATUS) ? {aborted_q, 1'b1, wr_acked_q} : '0;
    assign busy              = in_flight || (state_q == ST_STATUS);
    assign done              = done_q;

    // Next-state, counter and job-register update.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        dst_d       = dst_q;
        n_d         = n_q;
        rd_issued_d = rd_issued_q;
        wr_issued_d = wr_issued_q;
        wr_acked_d  = wr_acked_q;
        outs_d      = outs_q;
        aborted_d   = aborted_q;
        done_d      = done_q;

        if (rd_hs) begin
            rd_issued_d = rd_issued_q + 1'b1;
        end
        if (wr_hs) begin
            wr_issued_d = wr_issued_q + 1'b1;
        end
        if (rd_hs && !rsp_take) begin
            outs_d = outs_q + 1'b1;
        end else if (!rd_hs && rsp_take) begin
            outs_d = outs_q - 1'b1;
        end
        // Acks beyond the writes actually issued are dropped.
        if (in_flight && bus.wr_ack && (wr_acked_q < wr_issued_q)) begin
            wr_acked_d = wr_acked_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (csr_start) begin
                    src_d       = csr_src_addr;
                    dst_d       = csr_dst_addr;
                    n_d         = csr_num_lines;
                    rd_issued_d = '0;
                    wr_issued_d = '0;
                    wr_acked_d  = '0;
                    outs_d      = '0;
                    aborted_d   = 1'b0;
                    done_d      = 1'b0;
                    state_d     = (csr_num_lines != '0) ? ST_RUN : ST_STATUS;
                end
            end
            ST_RUN: begin
                // Abort wins over completion in the same cycle; DRAIN then finishes
                // immediately since everything is already acked.
                if (csr_abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_DRAIN;
                end else if (wr_acked_d == n_q) begin
                    state_d = ST_STATUS;
                end
            end
            ST_DRAIN: begin
                if ((outs_q == '0) && (wr_acked_q == wr_issued_q)) begin
                    state_d = ST_STATUS;
                end
            end
            ST_STATUS: begin
                if (bus.stat_wr_ready) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset abandons any job in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            n_q         <= '0;
            rd_issued_q <= '0;
            wr_issued_q <= '0;
            wr_acked_q  <= '0;
            outs_q      <= '0;
            aborted_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            n_q         <= n_d;
            rd_issued_q <= rd_issued_d;
            wr_issued_q <= wr_issued_d;
            wr_acked_q  <= wr_acked_d;
            outs_q      <= outs_d;
            aborted_q   <= aborted_d;
            done_q      <= done_d;
        end
    end

endmodule
